link_credit_tx: RTL
===================

LINK_CREDIT_TX -- requirements
Module: link_credit_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 32: payload width of one link word.
REQ-002 SHALL have parameter DEPTH, default 8 (power of two, >=2): input FIFO depth in words.
REQ-003 SHALL have parameter INIT_CREDITS, default 8 (1..255): receiver buffer slots granted at reset.
REQ-004 SHALL have port clk, input, 1: single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port in_valid, input, 1: muxed-stream word present; there is no backpressure.
REQ-007 SHALL have port in_ty, input, 1 (link_ty_e): word type, EVENT or DATA.
REQ-008 SHALL have port in_data, input, DATA_W: muxed-stream payload.
REQ-009 SHALL have port link_valid, output, 1: word on the link this cycle.
REQ-010 SHALL have port link_ty, output, 1: type of the link word.
REQ-011 SHALL have port link_data, output, DATA_W: payload of the link word.
REQ-012 SHALL have port credit_return, input, 1: one-cycle pulse; the receiver freed one slot.
REQ-013 SHALL have port credits, output, 8: current credit count.
REQ-014 SHALL have port level, output, $clog2(DEPTH)+1: FIFO occupancy.
REQ-015 SHALL have port overflow, output, 1: sticky; an input word was dropped.
REQ-016 SHALL have port credit_err, output, 1: sticky; a credit was returned while the count was at INIT_CREDITS.

Function
REQ-017 SHALL write {in_ty, in_data} into the FIFO on every cycle with in_valid=1, unless the word is dropped under REQ-022.
REQ-018 SHALL pop the FIFO head onto registered link_* outputs in any cycle where level>0 and credits>0; link_valid SHALL be 0 in all other cycles.
REQ-019 SHALL emit at most one link word per cycle, in strict input order; types SHALL pass through unchanged.
REQ-020 SHALL give a latency of exactly 1 cycle from in_valid to link_valid when the FIFO is empty and credits>0: input at edge N appears at edge N+1, with no bubble.
REQ-021 SHALL decrement credits by 1 per emitted word, increment by 1 per credit_return, and leave credits unchanged when both occur in the same cycle.
REQ-022 SHALL drop the input word and set overflow when in_valid=1, level=DEPTH and no pop occurs in that cycle; when a pop occurs in that cycle, the word SHALL be accepted.
REQ-023 SHALL saturate credits at INIT_CREDITS and set credit_err when credit_return=1, credits=INIT_CREDITS and no word is emitted in that cycle.
REQ-024 SHALL never allow credits to go below 0; no word is emitted at credits=0.
REQ-025 SHALL keep overflow and credit_err set until rst.
REQ-026 SHALL update level as +write -pop; simultaneous write and pop SHALL leave level unchanged.
REQ-027 SHALL make the FIFO pointers wrap modulo DEPTH, using an extra MSB to tell full from empty.

Reset
REQ-028 SHALL set, while rst=1: link_valid=0, link_ty=EVENT, link_data=0, credits=INIT_CREDITS, level=0, overflow=0, credit_err=0, FIFO pointers=0.
REQ-029 SHALL discard FIFO contents and ignore in_valid and credit_return in any cycle where rst=1, including mid-stream.
REQ-030 SHALL honour the first in_valid in the cycle after rst falls.

Structure
REQ-031 SHALL import link_ty_e (EVENT, DATA) and the link_word_t struct {ty, data} from the shared link package, and SHALL not redeclare them.
REQ-032 SHALL implement storage in one sub-module, sync_fifo, parameterized by width and DEPTH, with push, pop, head, level and full outputs; credit logic and output registers SHALL live in the top module.

Verification
REQ-033 SHALL cover: after reset, one EVENT word 0xA5 -> link_valid at the next edge with ty=EVENT, data=0xA5; credits=7.
REQ-034 SHALL cover: INIT_CREDITS=8, 12 back-to-back words and no returns -> 8 words out in order, credits=0, level=4, link_valid=0; then 4 credit_return pulses -> the remaining 4 words out, level=0.
REQ-035 SHALL cover: credits=0, 9 words pushed with DEPTH=8 -> the 9th is dropped and overflow=1; with credits=1 and level=8, a simultaneous push -> accepted, overflow stays 0.
REQ-036 SHALL cover: credits=8 and level=0, credit_return pulse -> credits stay 8 and credit_err=1; with a same-cycle emit and return at credits=3 -> credits remain 3.
REQ-037 SHALL cover: rst asserted with level=5 and credits=2 -> next cycle level=0, credits=8, link_valid=0; a word pushed in the first post-reset cycle appears one cycle later.
REQ-038 SHALL cover: alternating EVENT and DATA words across a pointer wrap (20 words, DEPTH=8) -> output order and ty preserved, scoreboard exact.

Source files
------------

// File: rtl/link_credit_tx_pkg.sv
// Shared link types: word type tag and the stored link word.
package link_credit_tx_pkg;

  typedef enum logic {
    EVENT = 1'b0,
    DATA  = 1'b1
  } link_ty_e;

  localparam int LINK_DATA_W = 64;

  typedef struct packed {
    link_ty_e               ty;
    logic [LINK_DATA_W-1:0] data;
  } link_word_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; pointers carry an extra MSB so full and
// empty are distinguished without a separate counter.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [LW-1:0] wr_ptr;
  logic [LW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign head  = mem[rd_ptr[AW-1:0]];
  assign level = wr_ptr - rd_ptr;
  assign full  = (level == LW'(DEPTH));

endmodule

// File: rtl/link_credit_tx.sv
// Credit-based link transmitter: buffers the muxed stream and
// sends one word per cycle while the receiver has free slots.
module link_credit_tx
  import link_credit_tx_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 8,
  parameter int INIT_CREDITS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  link_ty_e                in_ty,
  input  logic [DATA_W-1:0]       in_data,
  output logic                    link_valid,
  output link_ty_e                link_ty,
  output logic [DATA_W-1:0]       link_data,
  input  logic                    credit_return,
  output logic [7:0]              credits,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow,
  output logic                    credit_err
);

  localparam logic [7:0] CMAX = 8'(INIT_CREDITS);

  link_word_t wr_word;
  link_word_t head_word;
  logic       full;
  logic       pop;
  logic       push;
  logic [7:0] credits_nxt;
  logic       unused_head;

  assign pop  = (level != '0) && (credits != 8'd0);
  // A full FIFO still accepts when the head leaves this cycle.
  assign push = in_valid && (!full || pop);

  assign wr_word = '{ty: in_ty, data: LINK_DATA_W'(in_data)};
  assign unused_head = ^head_word.data;

  sync_fifo #(
    .W     ($bits(link_word_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (wr_word),
    .head  (head_word),
    .level (level),
    .full  (full)
  );

  always_comb begin
    credits_nxt = credits;
    if (pop && !credit_return)
      credits_nxt = credits - 8'd1;
    else if (!pop && credit_return && credits != CMAX)
      credits_nxt = credits + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      link_valid <= 1'b0;
      link_ty    <= EVENT;
      link_data  <= '0;
      credits    <= CMAX;
      overflow   <= 1'b0;
      credit_err <= 1'b0;
    end else begin
      link_valid <= pop;
      if (pop) begin
        link_ty   <= head_word.ty;
        link_data <= head_word.data[DATA_W-1:0];
      end
      credits <= credits_nxt;
      if (in_valid && full && !pop)
        overflow <= 1'b1;
      if (credit_return && !pop && credits == CMAX)
        credit_err <= 1'b1;
    end
  end

endmodule
